platform_collision_scanner: RTL and testbench

- Reader side of the platform position/activation bus driven by the platform generator/renderer.
- Once per frame, on a start tick, it scans all 93 platform slots one per clock.
- It decides whether the falling doodle's feet land on an active platform, then reports the hit index and platform top y to the doodle physics block.

---
 rtl/game_pkg.sv | 36 +++
 rtl/platform_collision_scanner_if.sv | 35 +++
 rtl/platform_collision_scanner_hit_check.sv | 50 +++++
 rtl/platform_collision_scanner.sv | 104 ++++++++++
 tb/tb_platform_collision_scanner.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// ============================================================================
//  game_pkg
//  Shared platform geometry, position type and scan FSM states.
//  Rev 1.0
// ============================================================================
`default_nettype none

package game_pkg;

  localparam int NUM_PLATFORMS = 93;
  localparam int PLATFORM_W    = 100;
  localparam int PLATFORM_H    = 30;
  localparam int DOODLE_W      = 80;
  localparam int DOODLE_H      = 80;
  localparam int FOOT_MARGIN   = 10;
  localparam int LAND_TOL      = 16;
  localparam int IDX_W         = 7;

  // [0] = top y, [1] = left x, each an 11-bit two's-complement value
  typedef logic signed [1:0][10:0] platform_pos_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic        [10:0] x;
    logic        [9:0]  y;
    logic signed [7:0]  vy;
  } doodle_snap_t;

endpackage

`default_nettype wire

// File: rtl/platform_collision_scanner_if.sv
// ============================================================================
//  platform_collision_scanner_if
//  Platform bus, doodle state and landing result between game blocks.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface platform_collision_scanner_if;
  import game_pkg::*;

  logic                                 start;
  logic          [10:0]                 doodle_x;
  logic          [9:0]                  doodle_y;
  logic signed   [7:0]                  doodle_vy;
  platform_pos_t [NUM_PLATFORMS-1:0]    platforms;
  logic          [NUM_PLATFORMS-1:0]    platform_activation;
  logic                                 busy;
  logic                                 done;
  logic                                 landed;
  logic          [IDX_W-1:0]            landed_index;
  logic signed   [10:0]                 landed_y;

  modport master (
    output start, doodle_x, doodle_y, doodle_vy, platforms, platform_activation,
    input  busy, done, landed, landed_index, landed_y
  );

  modport slave (
    input  start, doodle_x, doodle_y, doodle_vy, platforms, platform_activation,
    output busy, done, landed, landed_index, landed_y
  );

endinterface

`default_nettype wire

// File: rtl/platform_collision_scanner_hit_check.sv
// ============================================================================
//  platform_hit_check
//  Combinational landing test of one platform against the doodle snapshot.
//  Rev 1.0
// ============================================================================
`default_nettype none

module platform_hit_check
  import game_pkg::*;
(
  input  platform_pos_t plat_i,
  input  logic          active_i,
  input  doodle_snap_t  snap_i,
  output logic          hit_o
);

  localparam logic signed [12:0] DOODLE_H_S  = 13'(DOODLE_H);
  localparam logic signed [12:0] FOOT_L_S    = 13'(FOOT_MARGIN);
  localparam logic signed [12:0] FOOT_R_S    = 13'(DOODLE_W - FOOT_MARGIN);
  localparam logic signed [12:0] PLAT_W_S    = 13'(PLATFORM_W);
  localparam logic signed [12:0] LAND_TOL_S  = 13'(LAND_TOL);

  logic signed [12:0] py;
  logic signed [12:0] px;
  logic signed [12:0] sx;
  logic signed [12:0] feet;
  logic signed [12:0] band_end;
  logic signed [12:0] foot_left;
  logic signed [12:0] foot_right;
  logic signed [12:0] plat_right;
  logic               falling;

  // Platform fields are signed, doodle coordinates are unsigned screen values
  assign py         = {{2{plat_i[0][10]}}, plat_i[0]};
  assign px         = {{2{plat_i[1][10]}}, plat_i[1]};
  assign sx         = {2'b00, snap_i.x};
  assign feet       = {3'b000, snap_i.y} + DOODLE_H_S;
  assign band_end   = py + LAND_TOL_S;
  assign foot_left  = sx + FOOT_L_S;
  assign foot_right = sx + FOOT_R_S;
  assign plat_right = px + PLAT_W_S;
  assign falling    = snap_i.vy > 8'sd0;

  assign hit_o = active_i && falling
              && (feet >= py) && (feet < band_end)
              && (foot_right > px) && (foot_left < plat_right);

endmodule

`default_nettype wire

// File: rtl/platform_collision_scanner.sv
// ============================================================================
//  platform_collision_scanner
//  Per-frame sequential scan of all platform slots for a doodle landing.
//  Rev 1.0
// ============================================================================
`default_nettype none

module platform_collision_scanner
  import game_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  platform_collision_scanner_if.slave  bus
);

  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  doodle_snap_t       snap_q, snap_d;
  logic               landed_q, landed_d;
  logic [IDX_W-1:0]   landed_index_q, landed_index_d;
  logic signed [10:0] landed_y_q, landed_y_d;

  platform_pos_t      cur_plat;
  logic               cur_active;
  logic               hit;

  assign cur_plat   = bus.platforms[idx_q];
  assign cur_active = bus.platform_activation[idx_q];

  platform_hit_check u_hit_check (
    .plat_i   (cur_plat),
    .active_i (cur_active),
    .snap_i   (snap_q),
    .hit_o    (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      snap_q         <= '0;
      landed_q       <= 1'b0;
      landed_index_q <= '0;
      landed_y_q     <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      snap_q         <= snap_d;
      landed_q       <= landed_d;
      landed_index_q <= landed_index_d;
      landed_y_q     <= landed_y_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    snap_d         = snap_q;
    landed_d       = landed_q;
    landed_index_d = landed_index_q;
    landed_y_d     = landed_y_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d.x  = bus.doodle_x;
          snap_d.y  = bus.doodle_y;
          snap_d.vy = bus.doodle_vy;
          landed_d  = 1'b0;
          idx_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // Lowest-index hit wins; later hits leave the result untouched
        if (hit && !landed_q) begin
          landed_d       = 1'b1;
          landed_index_d = idx_q;
          landed_y_d     = cur_plat[0];
        end
        if (idx_q == IDX_W'(NUM_PLATFORMS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.landed       = landed_q;
  assign bus.landed_index = landed_index_q;
  assign bus.landed_y     = landed_y_q;

endmodule

`default_nettype wire

// File: tb/tb_platform_collision_scanner.sv
// ============================================================================
//  tb_platform_collision_scanner
//  Directed vector table plus reset/restart sequences for the scanner.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_platform_collision_scanner;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  platform_collision_scanner_if bus ();

  platform_collision_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int sa_idx; int sa_y; int sa_x;
    int sb_idx; int sb_y; int sb_x;
    int dx; int dy; int dvy;
    int e_land; int e_idx; int e_y;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_platforms();
    bus.platform_activation = '0;
    bus.platforms           = '0;
  endtask

  task automatic load_slot(input int idx, input int y, input int x);
    if (idx >= 0) begin
      bus.platform_activation[idx] = 1'b1;
      bus.platforms[idx][0]        = 11'(y);
      bus.platforms[idx][1]        = 11'(x);
    end
  endtask

  task automatic set_doodle(input int x, input int y, input int vy);
    bus.doodle_x  = 11'(x);
    bus.doodle_y  = 10'(y);
    bus.doodle_vy = 8'(vy);
  endtask

  // Cycle 1 is the first cycle after the edge that samples start
  task automatic run_scan(input int restart_at, input int rst_at,
                          output int done_cyc, output int busy_bad,
                          output int done_cnt, output int landed_at_rst);
    bit exp_busy;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    done_cyc      = 0;
    busy_bad      = 0;
    done_cnt      = 0;
    landed_at_rst = 0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      exp_busy = (cyc <= 94) && (rst_at == 0 || cyc <= rst_at);
      if (bus.busy != exp_busy) busy_bad++;
      if (cyc == restart_at) begin
        bus.start = 1'b1;
        set_doodle(0, 0, -2);
      end
      if (cyc == rst_at) begin
        landed_at_rst = int'(bus.landed);
        rst           = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst       = 1'b0;
    end
  endtask

  int dc, bb, dn, lr;

  initial begin
    bus.start = 1'b0;
    set_doodle(0, 0, 0);
    clear_platforms();

    vecs[0]  = '{-1,   0,   0, -1,   0,   0, 420, 220,  3, 0,  0,   0};
    vecs[1]  = '{40, 300, 400, -1,   0,   0, 420, 220,  3, 1, 40, 300};
    vecs[2]  = '{40, 300, 400, -1,   0,   0, 420, 235,  3, 1, 40, 300};
    vecs[3]  = '{40, 300, 400, -1,   0,   0, 420, 236,  3, 0, 40, 300};
    vecs[4]  = '{40, 300, 400, -1,   0,   0, 420, 220, -2, 0, 40, 300};
    vecs[5]  = '{40, 300, 400, -1,   0,   0, 420, 220,  0, 0, 40, 300};
    vecs[6]  = '{10, 300, 342, 50, 290, 400, 360, 225,  1, 1, 10, 300};
    vecs[7]  = '{ 5, 300, 400, -1,   0,   0, 490, 220,  1, 0, 10, 300};
    vecs[8]  = '{ 5, 300, 400, -1,   0,   0, 489, 220,  1, 1,  5, 300};
    vecs[9]  = '{ 5, 300, 400, -1,   0,   0, 330, 220,  1, 0,  5, 300};
    vecs[10] = '{ 5, 300, 400, -1,   0,   0, 331, 220,  1, 1,  5, 300};
    vecs[11] = '{ 3, -20, -50, -1,   0,   0,   0,   0,  1, 0,  5, 300};
    vecs[12] = '{ 3,  70, -50, -1,   0,   0,   0,   0,  1, 1,  3,  70};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy",         int'(bus.busy), 0);
    check("reset done",         int'(bus.done), 0);
    check("reset landed",       int'(bus.landed), 0);
    check("reset landed_index", int'(bus.landed_index), 0);
    check("reset landed_y",     int'($signed(bus.landed_y)), 0);

    for (int v = 0; v < 13; v++) begin
      clear_platforms();
      load_slot(vecs[v].sa_idx, vecs[v].sa_y, vecs[v].sa_x);
      load_slot(vecs[v].sb_idx, vecs[v].sb_y, vecs[v].sb_x);
      set_doodle(vecs[v].dx, vecs[v].dy, vecs[v].dvy);
      run_scan(0, 0, dc, bb, dn, lr);
      check($sformatf("v%0d done_cycle", v),   dc, 94);
      check($sformatf("v%0d busy_errors", v),  bb, 0);
      check($sformatf("v%0d done_pulses", v),  dn, 1);
      check($sformatf("v%0d landed", v),       int'(bus.landed), vecs[v].e_land);
      check($sformatf("v%0d landed_index", v), int'(bus.landed_index), vecs[v].e_idx);
      check($sformatf("v%0d landed_y", v),     int'($signed(bus.landed_y)), vecs[v].e_y);
    end

    // Second start mid-scan carries a non-falling doodle; it must be ignored
    clear_platforms();
    load_slot(40, 300, 400);
    set_doodle(420, 220, 3);
    run_scan(30, 0, dc, bb, dn, lr);
    check("restart done_cycle",   dc, 94);
    check("restart busy_errors",  bb, 0);
    check("restart done_pulses",  dn, 1);
    check("restart landed",       int'(bus.landed), 1);
    check("restart landed_index", int'(bus.landed_index), 40);
    check("restart landed_y",     int'($signed(bus.landed_y)), 300);

    // Reset in cycle 50 after slot 10 has already landed
    clear_platforms();
    load_slot(10, 300, 342);
    set_doodle(360, 225, 1);
    run_scan(0, 50, dc, bb, dn, lr);
    check("rst landed_before",  lr, 1);
    check("rst busy_errors",    bb, 0);
    check("rst done_pulses",    dn, 0);
    check("rst landed",         int'(bus.landed), 0);
    check("rst landed_index",   int'(bus.landed_index), 0);
    check("rst landed_y",       int'($signed(bus.landed_y)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
